// File: rtl/cardinal_pkg.sv
// Shared types and constants for the cardinal vector processor.
// Stage bundles, opcode/func/lane encodings and byte-merge helpers.
package cardinal_pkg;

  localparam logic [5:0] OP_ALU   = 6'b101010;
  localparam logic [5:0] OP_VLD   = 6'b100000;
  localparam logic [5:0] OP_VSD   = 6'b100001;
  localparam logic [5:0] OP_VBEZ  = 6'b100010;
  localparam logic [5:0] OP_VBNEZ = 6'b100011;
  localparam logic [5:0] OP_VNOP  = 6'b111100;

  localparam logic [5:0] F_AND = 6'b000001;
  localparam logic [5:0] F_OR  = 6'b000010;
  localparam logic [5:0] F_XOR = 6'b000011;
  localparam logic [5:0] F_NOT = 6'b000100;
  localparam logic [5:0] F_MOV = 6'b000101;
  localparam logic [5:0] F_ADD = 6'b000110;
  localparam logic [5:0] F_SUB = 6'b000111;
  localparam logic [5:0] F_SLL = 6'b001010;
  localparam logic [5:0] F_SRL = 6'b001011;
  localparam logic [5:0] F_SRA = 6'b001100;

  localparam logic [1:0] WW_B = 2'b00;
  localparam logic [1:0] WW_H = 2'b01;
  localparam logic [1:0] WW_W = 2'b10;
  localparam logic [1:0] WW_D = 2'b11;

  localparam logic [2:0] PPP_HI   = 3'b001;
  localparam logic [2:0] PPP_LO   = 3'b010;
  localparam logic [2:0] PPP_EVEN = 3'b011;
  localparam logic [2:0] PPP_ODD  = 3'b100;

  typedef enum logic [1:0] {
    K_NOP,
    K_ALU,
    K_LD,
    K_ST
  } kind_e;

  typedef struct packed {
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    kind_e       kind;
    logic        wen;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [5:0]  func;
    logic [1:0]  ww;
    logic [7:0]  wmask;
    logic [7:0]  addr;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] d;
  } id_ex_t;

  typedef struct packed {
    logic        wen;
    logic [4:0]  rd;
    logic [7:0]  wmask;
    logic [63:0] data;
  } ex_wb_t;

  // wmask bit i covers bits [8i+7:8i]; byte 0 (MSB) is bit 7
  function automatic logic [7:0] ppp_mask(input logic [2:0] p);
    logic [7:0] m;
    case (p)
      PPP_HI:   m = 8'hF0;
      PPP_LO:   m = 8'h0F;
      PPP_EVEN: m = 8'hAA;
      PPP_ODD:  m = 8'h55;
      default:  m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic func_ok(input logic [5:0] f);
    return f inside {F_AND, F_OR, F_XOR, F_NOT, F_MOV,
                     F_ADD, F_SUB, F_SLL, F_SRL, F_SRA};
  endfunction

  function automatic logic [63:0] merge(
    input logic [63:0] n,
    input logic [63:0] o,
    input logic [7:0]  m
  );
    logic [63:0] r;
    for (int i = 0; i < 8; i++)
      r[8*i +: 8] = m[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // Register value as seen after the pending WB write lands
  function automatic logic [63:0] rd_reg(
    input logic [4:0]  r,
    input logic [63:0] v,
    input ex_wb_t      wb
  );
    logic [63:0] x;
    x = v;
    if (r == 5'd0)
      x = '0;
    else if (wb.wen && wb.rd == r)
      x = merge(wb.data, v, wb.wmask);
    return x;
  endfunction

endpackage

// File: rtl/cardinal_alu.sv
// Lane-partitioned 64-bit vector ALU.
// Carries and shifts stay inside each lane of the selected width.
import cardinal_pkg::*;

module cardinal_alu (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [5:0]  func_i,
  input  logic [1:0]  ww_i,
  output logic [63:0] res_o
);

  function automatic logic [63:0] lane_op(
    input logic [5:0]  f,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [6:0]  w
  );
    logic [63:0] m;
    logic [63:0] amt;
    logic [63:0] r;
    logic        sgn;
    m   = (64'd1 << w) - 64'd1;
    amt = b & {57'd0, w - 7'd1};
    sgn = |(a & (64'd1 << (w - 7'd1)));
    case (f)
      F_AND:   r = a & b;
      F_OR:    r = a | b;
      F_XOR:   r = a ^ b;
      F_NOT:   r = ~a;
      F_MOV:   r = a;
      F_ADD:   r = a + b;
      F_SUB:   r = a - b;
      F_SLL:   r = a << amt;
      F_SRL:   r = a >> amt;
      F_SRA:   r = (a >> amt) | (sgn ? ~(m >> amt) : '0);
      default: r = '0;
    endcase
    return r & m;
  endfunction

  logic [63:0] t;

  always_comb begin
    t     = '0;
    res_o = '0;
    unique case (ww_i)
      WW_B:
        for (int i = 0; i < 8; i++) begin
          t = lane_op(func_i, {56'd0, a_i[8*i +: 8]},
                      {56'd0, b_i[8*i +: 8]}, 7'd8);
          res_o[8*i +: 8] = t[7:0];
        end
      WW_H:
        for (int i = 0; i < 4; i++) begin
          t = lane_op(func_i, {48'd0, a_i[16*i +: 16]},
                      {48'd0, b_i[16*i +: 16]}, 7'd16);
          res_o[16*i +: 16] = t[15:0];
        end
      WW_W:
        for (int i = 0; i < 2; i++) begin
          t = lane_op(func_i, {32'd0, a_i[32*i +: 32]},
                      {32'd0, b_i[32*i +: 32]}, 7'd32);
          res_o[32*i +: 32] = t[31:0];
        end
      WW_D: begin
        t     = lane_op(func_i, a_i, b_i, 7'd64);
        res_o = t;
      end
    endcase
  end

endmodule

// File: rtl/cardinal_processor.sv
// Four-stage (IF, ID, EX/MEM, WB) 64-bit vector processor core.
// Branches resolve in ID; WB results are forwarded into ID and EX.
import cardinal_pkg::*;

module cardinal_processor (
  input  logic        Clock,
  input  logic        Reset,
  output logic [0:7]  Instr_Addr,
  input  logic [0:31] Instruction,
  output logic [0:7]  Mem_Addr,
  output logic [0:63] Data_Out,
  input  logic [0:63] Data_In,
  output logic        DmemEn,
  output logic        DmemWrEn
);

  logic [7:0] pc_q, pc_d;
  if_id_t     if_id_q, if_id_d;
  id_ex_t     id_ex_q, id_ex_d;
  ex_wb_t     ex_wb_q, ex_wb_d;

  logic [31:0] ins;
  logic [5:0]  op, fn;
  logic [4:0]  rd, ra, rb;
  logic [2:0]  ppp;
  logic [1:0]  ww;
  logic [7:0]  imm8;
  logic [63:0] id_a, id_b, id_d;

  assign ins  = if_id_q.instr;
  assign op   = ins[31:26];
  assign rd   = ins[25:21];
  assign ra   = ins[20:16];
  assign rb   = ins[15:11];
  assign ppp  = ins[10:8];
  assign ww   = ins[7:6];
  assign fn   = ins[5:0];
  assign imm8 = ins[7:0];

  generate
    if (1'b1) begin : rf
      logic [63:0] data_arr [0:31];

      always_ff @(posedge Clock) begin
        if (Reset) begin
          for (int i = 0; i < 32; i++)
            data_arr[i] <= '0;
        end else if (ex_wb_q.wen && ex_wb_q.rd != 5'd0) begin
          data_arr[ex_wb_q.rd] <= merge(ex_wb_q.data,
            data_arr[ex_wb_q.rd], ex_wb_q.wmask);
        end
      end

      assign id_a = rd_reg(ra, data_arr[ra], ex_wb_q);
      assign id_b = rd_reg(rb, data_arr[rb], ex_wb_q);
      assign id_d = rd_reg(rd, data_arr[rd], ex_wb_q);
    end
  endgenerate

  logic is_br, stall, taken;

  // The branch operand is only ready once its producer leaves EX
  assign is_br = (op == OP_VBEZ) || (op == OP_VBNEZ);
  assign stall = is_br && rd != 5'd0 && id_ex_q.wen
              && id_ex_q.rd == rd;
  assign taken = is_br && !stall
              && ((op == OP_VBEZ) == (id_d == 64'd0));

  always_comb begin
    pc_d          = pc_q + 8'd1;
    if_id_d.instr = Instruction;
    if (stall) begin
      pc_d    = pc_q;
      if_id_d = if_id_q;
    end else if (taken) begin
      pc_d          = imm8;
      if_id_d.instr = '0;
    end
  end

  always_comb begin
    id_ex_d = '0;
    if (!stall) begin
      id_ex_d.rd   = rd;
      id_ex_d.ra   = ra;
      id_ex_d.rb   = rb;
      id_ex_d.func = fn;
      id_ex_d.ww   = ww;
      id_ex_d.addr = imm8;
      id_ex_d.a    = id_a;
      id_ex_d.b    = id_b;
      id_ex_d.d    = id_d;
      unique case (1'b1)
        (op == OP_ALU) && func_ok(fn): begin
          id_ex_d.kind  = K_ALU;
          id_ex_d.wen   = rd != 5'd0;
          id_ex_d.wmask = ppp_mask(ppp);
        end
        op == OP_VLD: begin
          id_ex_d.kind  = K_LD;
          id_ex_d.wen   = rd != 5'd0;
          id_ex_d.wmask = 8'hFF;
        end
        op == OP_VSD:
          id_ex_d.kind = K_ST;
        default: ;
      endcase
    end
  end

  logic [63:0] ex_a, ex_b, ex_d, alu_res;

  assign ex_a = rd_reg(id_ex_q.ra, id_ex_q.a, ex_wb_q);
  assign ex_b = rd_reg(id_ex_q.rb, id_ex_q.b, ex_wb_q);
  assign ex_d = rd_reg(id_ex_q.rd, id_ex_q.d, ex_wb_q);

  cardinal_alu u_alu (
    .a_i    (ex_a),
    .b_i    (ex_b),
    .func_i (id_ex_q.func),
    .ww_i   (id_ex_q.ww),
    .res_o  (alu_res)
  );

  always_comb begin
    ex_wb_d.wen   = id_ex_q.wen;
    ex_wb_d.rd    = id_ex_q.rd;
    ex_wb_d.wmask = id_ex_q.wmask;
    ex_wb_d.data  = (id_ex_q.kind == K_LD) ? Data_In : alu_res;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q    <= '0;
      if_id_q <= '0;
      id_ex_q <= '0;
      ex_wb_q <= '0;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
      id_ex_q <= id_ex_d;
      ex_wb_q <= ex_wb_d;
    end
  end

  logic is_ld, is_st;

  // Gated by Reset so nothing reaches memory in a reset cycle
  assign is_ld = !Reset && id_ex_q.kind == K_LD;
  assign is_st = !Reset && id_ex_q.kind == K_ST;

  assign Instr_Addr = pc_q;
  assign DmemEn     = is_ld | is_st;
  assign DmemWrEn   = is_st;
  assign Mem_Addr   = (is_ld | is_st) ? id_ex_q.addr : 8'd0;
  assign Data_Out   = is_st ? ex_d : 64'd0;

endmodule

// File: tb/tb_cardinal_processor.sv
// Scoreboard bench for cardinal_processor: an ISA-level model
// predicts the store stream, a monitor checks the data bus.
module tb_cardinal_processor;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [0:7]  Instr_Addr;
  logic [0:31] Instruction;
  logic [0:7]  Mem_Addr;
  logic [0:63] Data_Out;
  logic [0:63] Data_In;
  logic        DmemEn;
  logic        DmemWrEn;

  cardinal_processor dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Instr_Addr  (Instr_Addr),
    .Instruction (Instruction),
    .Mem_Addr    (Mem_Addr),
    .Data_Out    (Data_Out),
    .Data_In     (Data_In),
    .DmemEn      (DmemEn),
    .DmemWrEn    (DmemWrEn)
  );

  always #5 Clock = ~Clock;

  logic [31:0] imem [256];
  logic [63:0] dmem [256];
  int unsigned seed = 0;
  int          tests = 0;
  int          fails = 0;
  logic [71:0] exp_q [$];

  assign Instruction = imem[Instr_Addr];
  assign Data_In     = dmem[Mem_Addr];

  function automatic logic [63:0] init_val(input int i, input int unsigned s);
    if (s == 0) begin
      if (i == 0) return 64'h01020304050607FF;
      if (i == 1) return 64'h0101010101010101;
      return 64'd0;
    end
    if (i % 5 == 0) return '1;
    return {(s * 32'h9E3779B9) ^ 32'(i), (s + 32'(i)) * 32'h85EBCA6B};
  endfunction

  // Data memory reloads while Reset is held, else takes DUT stores
  always @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_val(i, seed);
    end else if (DmemWrEn) begin
      dmem[Mem_Addr] <= Data_Out;
    end
  end

  task automatic chk(input string nm, input logic [95:0] got,
                     input logic [95:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  always @(negedge Clock) begin
    if (!Reset) begin
      if (DmemWrEn) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_store addr=%0d data=%h",
                   Mem_Addr, Data_Out);
        end else begin
          chk("store", {23'd0, DmemEn, Mem_Addr, Data_Out},
              {23'd0, 1'b1, exp_q.pop_front()});
        end
      end
      if (!DmemEn)
        chk("idle_bus", {23'd0, DmemWrEn, Mem_Addr, Data_Out}, '0);
    end
  end

  localparam logic [5:0] ALU = 6'b101010, VLD = 6'b100000, VSD = 6'b100001;
  localparam logic [5:0] BEZ = 6'b100010, BNZ = 6'b100011, NOPC = 6'b111100;

  function automatic logic [31:0] ialu(input logic [5:0] fn,
    input logic [1:0] ww, input logic [2:0] p, input int d, a, b);
    return {ALU, 5'(d), 5'(a), 5'(b), p, ww, fn};
  endfunction

  function automatic logic [31:0] imop(input logic [5:0] op,
    input int d, input int im);
    return {op, 5'(d), 5'd0, 8'd0, 8'(im)};
  endfunction

  // Reference semantics: split into lanes, do plain modular arithmetic
  function automatic bit ref_alu(input logic [5:0] fn, input logic [1:0] ww,
    input logic [63:0] a, input logic [63:0] b, output logic [63:0] res);
    int w;
    logic [63:0] m, x, y, z;
    longint sx;
    int s;
    w   = 8 << ww;
    m   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    res = '0;
    for (int k = 0; k < 64 / w; k++) begin
      x = (a >> (k * w)) & m;
      y = (b >> (k * w)) & m;
      s = int'(y % 64'(w));
      case (fn)
        6'd1:  z = x & y;
        6'd2:  z = x | y;
        6'd3:  z = x ^ y;
        6'd4:  z = ~x;
        6'd5:  z = x;
        6'd6:  z = x + y;
        6'd7:  z = x - y;
        6'd10: z = x << s;
        6'd11: z = x >> s;
        6'd12: begin
          sx = $signed(x << (64 - w)) >>> (64 - w);
          z  = 64'(sx >>> s);
        end
        default: return 1'b0;
      endcase
      res = res | ((z & m) << (k * w));
    end
    return 1'b1;
  endfunction

  function automatic bit part(input logic [2:0] p, input int b);
    case (p)
      3'd1: return b < 4;
      3'd2: return b >= 4;
      3'd3: return b % 2 == 0;
      3'd4: return b % 2 == 1;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model(input int unsigned s);
    logic [63:0] r [32];
    logic [63:0] mm [256];
    logic [63:0] res, nv;
    logic [31:0] ins;
    logic [4:0]  d, a, b;
    logic [7:0]  im;
    int pc, nxt;
    for (int i = 0; i < 32; i++) r[i] = '0;
    for (int i = 0; i < 256; i++) mm[i] = init_val(i, s);
    pc = 0;
    for (int st = 0; st < 2000; st++) begin
      ins = imem[pc];
      d   = ins[25:21];
      a   = ins[20:16];
      b   = ins[15:11];
      im  = ins[7:0];
      nxt = (pc + 1) % 256;
      case (ins[31:26])
        ALU: if (ref_alu(ins[5:0], ins[7:6], r[a], r[b], res)) begin
          nv = r[d];
          for (int k = 0; k < 8; k++)
            if (part(ins[10:8], k)) nv[(7-k)*8 +: 8] = res[(7-k)*8 +: 8];
          if (d != 0) r[d] = nv;
        end
        VLD: if (d != 0) r[d] = mm[im];
        VSD: begin
          mm[im] = r[d];
          exp_q.push_back({im, r[d]});
        end
        BEZ: if (r[d] == 0) nxt = int'(im);
        BNZ: if (r[d] != 0) nxt = int'(im);
        default: ;
      endcase
      if (nxt == pc) break;
      pc = nxt;
    end
  endtask

  task automatic gen_prog(input int len);
    logic [5:0] fl [11] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6,
                            6'd7, 6'd10, 6'd11, 6'd12, 6'd9};
    int r, tg;
    for (int i = 0; i < 256; i++) imem[i] = '0;
    for (int pc = 0; pc < len; pc++) begin
      r = $urandom_range(0, 99);
      if (r < 50)
        imem[pc] = ialu(fl[$urandom_range(0, 10)], 2'($urandom_range(0, 3)),
                        3'($urandom_range(0, 7)), $urandom_range(0, 7),
                        $urandom_range(0, 7), $urandom_range(0, 7));
      else if (r < 65)
        imem[pc] = imop(VLD, $urandom_range(0, 7), $urandom_range(0, 31));
      else if (r < 80)
        imem[pc] = imop(VSD, $urandom_range(0, 7), $urandom_range(16, 31));
      else if (r < 90) begin
        tg = pc + $urandom_range(1, 4);
        if (tg > len) tg = len;
        imem[pc] = imop(r < 85 ? BEZ : BNZ, $urandom_range(0, 7), tg);
      end else
        imem[pc] = (r < 95) ? {NOPC, 26'($urandom)} : $urandom & 32'h03FF_FFFF;
    end
    for (int k = 1; k < 8; k++) imem[len + k - 1] = imop(VSD, k, 32 + k);
    imem[len + 7] = imop(BEZ, 0, len + 7);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge Clock);
      n++;
    end
    chk({nm, "_drain"}, 96'(exp_q.size()), 96'd0);
    repeat (8) @(negedge Clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = '0;
    imem[0]  = imop(VLD, 1, 0);
    imem[1]  = imop(VLD, 2, 1);
    imem[2]  = ialu(6'd6, 2'b00, 3'd0, 3, 1, 2);
    imem[3]  = imop(VSD, 3, 5);
    imem[4]  = ialu(6'd6, 2'b11, 3'd0, 3, 1, 2);
    imem[5]  = imop(VSD, 3, 6);
    imem[6]  = ialu(6'd7, 2'b10, 3'd0, 5, 2, 1);
    imem[7]  = imop(VSD, 5, 7);
    imem[8]  = imop(BEZ, 0, 10);
    imem[9]  = imop(VSD, 1, 20);
    imem[10] = ialu(6'd4, 2'b11, 3'd0, 6, 0, 0);
    imem[11] = ialu(6'd3, 2'b11, 3'd3, 4, 6, 0);
    imem[12] = imop(VSD, 4, 8);
    imem[13] = ialu(6'd3, 2'b11, 3'd0, 0, 6, 0);
    imem[14] = imop(VSD, 0, 9);
    imem[15] = imop(BNZ, 0, 0);
    imem[16] = ialu(6'd4, 2'b11, 3'd0, 7, 0, 0);
    imem[17] = imop(BNZ, 7, 20);
    imem[18] = imop(VSD, 1, 21);
    imem[21] = imop(VSD, 7, 11);
    imem[22] = imop(BEZ, 0, 22);

    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("reset_bus", {14'd0, Instr_Addr, DmemEn, DmemWrEn, Mem_Addr, Data_Out}, '0);
    exp_q.push_back({8'd5,  64'h0203040506070800});
    exp_q.push_back({8'd6,  64'h0203040506070900});
    exp_q.push_back({8'd7,  64'hFFFEFDFDFBFAF902});
    exp_q.push_back({8'd8,  64'hFF00FF00FF00FF00});
    exp_q.push_back({8'd9,  64'h0});
    exp_q.push_back({8'd11, 64'hFFFFFFFFFFFFFFFF});
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    chk("first_fetch", {87'd0, Instr_Addr, DmemEn}, 96'd0);
    @(negedge Clock);
    chk("second_fetch", {88'd0, Instr_Addr}, 96'd1);
    drain("directed");

    for (int p = 1; p <= 6; p++) begin
      @(posedge Clock);
      #1 Reset = 1'b1;
      seed = 32'(p) * 7 + 1;
      exp_q.delete();
      gen_prog(30 + 4 * p);
      model(seed);
      if (p == 3) begin
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;
        repeat (15) @(posedge Clock);
        #1 Reset = 1'b1;
        @(negedge Clock);
        chk("midreset_bus", {86'd0, DmemEn, DmemWrEn, Mem_Addr}, '0);
        exp_q.delete();
        model(seed);
      end
      repeat (3) @(posedge Clock);
      #1 Reset = 1'b0;
      drain("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
